mrisc_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the KGP miniRISC datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
//  and drives the PC, IR, register-file, ALU-source and data-memory strobes. Instruction and data memories have
//  req/ack handshakes with variable wait states, guarded by a timeout. Sits between main_control decode and the datapath.

---
 rtl/mrisc_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mrisc_multicycle_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mrisc_multicycle_ctrl.sv
// mrisc_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP miniRISC datapath.
// Define PERF_CNT_EN to add the cycle_cnt / retire_cnt performance counter outputs.
module mrisc_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter logic [5:0]  OP_RTYPE    = 6'h00,
   parameter logic [5:0]  OP_ALUI     = 6'h01,
   parameter logic [5:0]  OP_LD       = 6'h02,
   parameter logic [5:0]  OP_ST       = 6'h03,
   parameter logic [5:0]  OP_BR       = 6'h04,
   parameter logic [5:0]  OP_HALT     = 6'h3F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  opcode,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        branch_taken,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        alu_src,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        halted,
   output logic        error,
   output logic [2:0]  state
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retire_cnt
`endif
);

   localparam int unsigned CW = (MEM_TIMEOUT < 32'd2) ? 1 : $clog2(MEM_TIMEOUT + 32'd1);
   localparam logic [CW-1:0] LAST_WAIT = (MEM_TIMEOUT == 32'd0) ? '0 : CW'(MEM_TIMEOUT - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE = 3'd0,
      C_ALUI  = 3'd1,
      C_LD    = 3'd2,
      C_ST    = 3'd3,
      C_BR    = 3'd4
   } class_t;

   state_t          state_r;
   state_t          next_s;
   class_t          class_r;
   logic [CW-1:0]   wait_cnt_r;
   logic            timeout_s;

   function automatic class_t decode_class(input logic [5:0] op);
      class_t c;
      case (op)
         OP_ALUI: c = C_ALUI;
         OP_LD:   c = C_LD;
         OP_ST:   c = C_ST;
         OP_BR:   c = C_BR;
         default: c = C_RTYPE;
      endcase
      return c;
   endfunction

   // The last permitted wait cycle without an ack; an ack arriving on it still wins.
   assign timeout_s = (MEM_TIMEOUT != 32'd0) && (wait_cnt_r == LAST_WAIT);

   // State, opcode class and wait counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= S_IDLE;
         class_r    <= C_RTYPE;
         wait_cnt_r <= '0;
      end else begin
         state_r <= next_s;
         if (state_r == S_DECODE) begin
            class_r <= decode_class(opcode);
         end
         if ((state_r == S_FETCH && !imem_ack) || (state_r == S_MEM && !dmem_ack)) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
         end else begin
            wait_cnt_r <= '0;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) next_s = S_FETCH;
            else       next_s = S_IDLE;
         end
         S_FETCH: begin
            if (imem_ack)       next_s = S_DECODE;
            else if (timeout_s) next_s = S_ERR;
            else                next_s = S_FETCH;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE, OP_ALUI, OP_LD, OP_ST, OP_BR: next_s = S_EXEC;
               OP_HALT:                                next_s = S_HALT;
               default:                                next_s = S_ERR;
            endcase
         end
         S_EXEC: begin
            case (class_r)
               C_RTYPE, C_ALUI: next_s = S_WB;
               C_LD, C_ST:      next_s = S_MEM;
               C_BR:            next_s = S_FETCH;
               default:         next_s = S_ERR;
            endcase
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (class_r == C_ST) next_s = S_FETCH;
               else                 next_s = S_WB;
            end else if (timeout_s) begin
               next_s = S_ERR;
            end else begin
               next_s = S_MEM;
            end
         end
         S_WB:    next_s = S_FETCH;
         S_HALT:  next_s = S_HALT;
         S_ERR:   next_s = S_ERR;
         default: next_s = S_ERR;
      endcase
   end

   // Datapath strobes decoded from state, latched class and the acks.
   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      halted     = 1'b0;
      error      = 1'b0;
      case (state_r)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_write = imem_ack;
         end
         S_EXEC: begin
            alu_src = (class_r == C_ALUI) || (class_r == C_LD) || (class_r == C_ST);
            if (class_r == C_BR) begin
               pc_write = 1'b1;
               pc_src   = branch_taken;
            end else begin
               pc_write = 1'b0;
               pc_src   = 1'b0;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (class_r == C_ST);
            pc_write = dmem_ack && (class_r == C_ST);
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (class_r == C_LD);
            pc_write   = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         S_ERR:   error  = 1'b1;
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   assign state = state_r;

`ifdef PERF_CNT_EN
   // Active-cycle and retired-instruction counters, both free-running with wrap.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt  <= 32'd0;
         retire_cnt <= 32'd0;
      end else begin
         if (state_r != S_IDLE && state_r != S_HALT && state_r != S_ERR) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         if (pc_write) begin
            retire_cnt <= retire_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mrisc_multicycle_ctrl.sv
// Table-driven bench for mrisc_multicycle_ctrl (MEM_TIMEOUT=4) plus latency sequences.
module tb_mrisc_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, imem_ack, dmem_ack, branch_taken;
   logic [5:0]  opcode;
   logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
   logic        alu_src, mem_to_reg, reg_write, halted, error;
   logic [2:0]  state;
   logic [10:0] got;

   mrisc_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .halted(halted), .error(error), .state(state)
   );

   always #5 clk = ~clk;

   assign got = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                 alu_src, mem_to_reg, reg_write, halted, error};

   // {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_src,alu_src,mem_to_reg,reg_write,halted,error}
   localparam logic [10:0] O_NONE = 11'b000_0000_0000;
   localparam logic [10:0] O_FREQ = 11'b100_0000_0000;
   localparam logic [10:0] O_FACK = 11'b100_1000_0000;
   localparam logic [10:0] O_EXI  = 11'b000_0001_0000;
   localparam logic [10:0] O_WBR  = 11'b000_0100_0100;
   localparam logic [10:0] O_WBL  = 11'b000_0100_1100;
   localparam logic [10:0] O_MLD  = 11'b010_0000_0000;
   localparam logic [10:0] O_MST  = 11'b011_0000_0000;
   localparam logic [10:0] O_MSTA = 11'b011_0100_0000;
   localparam logic [10:0] O_BRT  = 11'b000_0110_0000;
   localparam logic [10:0] O_BRN  = 11'b000_0100_0000;
   localparam logic [10:0] O_HLT  = 11'b000_0000_0010;
   localparam logic [10:0] O_ERR  = 11'b000_0000_0001;

   typedef struct {
      logic        rst;
      logic        start;
      logic [5:0]  op;
      logic        iack;
      logic        dack;
      logic        bt;
      logic [2:0]  st;
      logic [10:0] outs;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic r, input logic s, input logic [5:0] op, input logic ia,
                      input logic da, input logic bt, input logic [2:0] st, input logic [10:0] o);
      vec_t v;
      v.rst = r; v.start = s; v.op = op; v.iack = ia; v.dack = da; v.bt = bt;
      v.st = st; v.outs = o;
      tbl.push_back(v);
   endtask

   // Runs from FETCH with zero-wait acks; counts cycles up to and including the pc_write cycle.
   task automatic measure(input logic [5:0] op, input int want, input string nm);
      int cyc = 0;
      bit seen = 1'b0;
      rst = 1'b1; start = 1'b0; opcode = op;
      imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (pc_write) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (seen) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (!seen || cyc != want) begin
         n_bad++;
         $display("FAIL latency_%s: got %0d cycles (seen=%0d) want %0d", nm, cyc, seen, want);
      end
   endtask

   initial begin
      // reset and idle, acks ignored while idle
      for (int i = 0; i < 10; i++) add(1, 0, 6'h00, 0, 0, 0, 3'd0, O_NONE);
      add(1, 0, 6'h00, 1, 1, 0, 3'd0, O_NONE);
      // RTYPE, zero wait
      add(1, 1, 6'h00, 0, 0, 0, 3'd0, O_NONE);
      add(1, 0, 6'h00, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h00, 0, 0, 0, 3'd2, O_NONE);
      add(1, 0, 6'h00, 0, 0, 0, 3'd3, O_NONE);
      add(1, 0, 6'h00, 0, 0, 0, 3'd5, O_WBR);
      // LD with three data wait states; ack on the last permitted wait cycle wins
      add(1, 0, 6'h02, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h02, 0, 0, 0, 3'd2, O_NONE);
      add(1, 0, 6'h02, 0, 0, 0, 3'd3, O_EXI);
      add(1, 0, 6'h02, 0, 0, 0, 3'd4, O_MLD);
      add(1, 0, 6'h02, 0, 0, 0, 3'd4, O_MLD);
      add(1, 0, 6'h02, 0, 0, 0, 3'd4, O_MLD);
      add(1, 0, 6'h02, 0, 1, 0, 3'd4, O_MLD);
      add(1, 0, 6'h02, 0, 0, 0, 3'd5, O_WBL);
      // BR taken, with a stray dmem_ack during fetch and start ignored
      add(1, 1, 6'h04, 0, 1, 0, 3'd1, O_FREQ);
      add(1, 0, 6'h04, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h04, 0, 0, 0, 3'd2, O_NONE);
      add(1, 0, 6'h04, 0, 0, 1, 3'd3, O_BRT);
      // ST with one wait state
      add(1, 0, 6'h03, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h03, 0, 0, 0, 3'd2, O_NONE);
      add(1, 0, 6'h03, 0, 0, 0, 3'd3, O_EXI);
      add(1, 0, 6'h03, 0, 0, 0, 3'd4, O_MST);
      add(1, 0, 6'h03, 0, 1, 0, 3'd4, O_MSTA);
      // ALUI, then BR not taken
      add(1, 0, 6'h01, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h01, 0, 0, 0, 3'd2, O_NONE);
      add(1, 0, 6'h01, 0, 0, 0, 3'd3, O_EXI);
      add(1, 0, 6'h01, 0, 0, 0, 3'd5, O_WBR);
      add(1, 0, 6'h04, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h04, 0, 0, 0, 3'd2, O_NONE);
      add(1, 0, 6'h04, 0, 0, 0, 3'd3, O_BRN);
      // HALT is sticky until reset
      add(1, 0, 6'h3F, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h3F, 0, 0, 0, 3'd2, O_NONE);
      for (int i = 0; i < 3; i++) add(1, 1, 6'h00, 1, 1, 1, 3'd6, O_HLT);
      add(0, 0, 6'h00, 0, 0, 0, 3'd6, O_HLT);
      add(1, 0, 6'h00, 0, 0, 0, 3'd0, O_NONE);
      // illegal opcode is sticky until reset
      add(1, 1, 6'h15, 0, 0, 0, 3'd0, O_NONE);
      add(1, 0, 6'h15, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h15, 0, 0, 0, 3'd2, O_NONE);
      for (int i = 0; i < 3; i++) add(1, 1, 6'h00, 1, 1, 0, 3'd7, O_ERR);
      add(0, 0, 6'h00, 0, 0, 0, 3'd7, O_ERR);
      add(1, 0, 6'h00, 0, 0, 0, 3'd0, O_NONE);
      // fetch timeout after four unanswered req cycles
      add(1, 1, 6'h00, 0, 0, 0, 3'd0, O_NONE);
      for (int i = 0; i < 4; i++) add(1, 0, 6'h00, 0, 0, 0, 3'd1, O_FREQ);
      add(1, 0, 6'h00, 1, 0, 0, 3'd7, O_ERR);
      add(0, 0, 6'h00, 0, 0, 0, 3'd7, O_ERR);
      // store timeout in MEM, no pc_write
      add(1, 1, 6'h03, 0, 0, 0, 3'd0, O_NONE);
      add(1, 0, 6'h03, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h03, 0, 0, 0, 3'd2, O_NONE);
      add(1, 0, 6'h03, 0, 0, 0, 3'd3, O_EXI);
      for (int i = 0; i < 4; i++) add(1, 0, 6'h03, 0, 0, 0, 3'd4, O_MST);
      add(1, 0, 6'h03, 0, 1, 0, 3'd7, O_ERR);
      add(0, 0, 6'h00, 0, 0, 0, 3'd7, O_ERR);
      // reset in the middle of a load drops dmem_req next cycle
      add(1, 1, 6'h02, 0, 0, 0, 3'd0, O_NONE);
      add(1, 0, 6'h02, 1, 0, 0, 3'd1, O_FACK);
      add(1, 0, 6'h02, 0, 0, 0, 3'd2, O_NONE);
      add(1, 0, 6'h02, 0, 0, 0, 3'd3, O_EXI);
      add(1, 0, 6'h02, 0, 0, 0, 3'd4, O_MLD);
      add(0, 0, 6'h02, 0, 0, 0, 3'd4, O_MLD);
      add(1, 0, 6'h02, 0, 1, 0, 3'd0, O_NONE);
      add(1, 0, 6'h02, 0, 0, 0, 3'd0, O_NONE);

      rst = 1'b0; start = 1'b0; opcode = 6'h00;
      imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[k]) begin
         rst = tbl[k].rst; start = tbl[k].start; opcode = tbl[k].op;
         imem_ack = tbl[k].iack; dmem_ack = tbl[k].dack; branch_taken = tbl[k].bt;
         @(negedge clk);
         n_cmp++;
         if (state !== tbl[k].st || got !== tbl[k].outs) begin
            n_bad++;
            $display("FAIL row_%0d: state/outs got %0d/%b want %0d/%b",
                     k, state, got, tbl[k].st, tbl[k].outs);
         end
         @(posedge clk); #1;
      end

      // zero-wait latencies, chained back to back from FETCH
      rst = 1'b1; start = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
      @(posedge clk); #1;
      measure(6'h00, 4, "rtype");
      measure(6'h01, 4, "alui");
      measure(6'h04, 3, "br");
      measure(6'h03, 4, "st");
      measure(6'h02, 5, "ld");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
